i2c_master_byte: RTL and testbench

//  Single-byte I2C master that drives the shared SCL/SDA bus feeding the i2c

---
 rtl/i2c_master_byte.sv | 180 ++++++++++++++++++
 tb/tb_i2c_master_byte.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, addr+RW, ACK, one data byte, ACK/NACK, STOP.
// Optional slave clock stretching is enabled with `define I2C_MASTER_CLK_STRETCH_EN.
module i2c_master_byte #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MACK, STOP
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic [1:0]     q;
    logic [2:0]     bit_idx;
    logic [7:0]     tx_sh, rx_sh, wdata_q;
    logic           rw_q, nack_q;
    logic           scl_s1, scl_s2, sda_s1, sda_s2;
    logic           last_cnt, freeze, tick, cell_end, sample, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
        end
    end

    assign last_cnt = (cnt == CW'(CLK_DIV - 1));

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // The first two clk of Q2 still see the low level we drove in Q1 through
    // the synchroniser, so they are excluded from the stretch check.
    assign freeze = (state != IDLE) && q[1] && !scl_s2 &&
                    !((q == 2'd2) && (cnt < CW'(2)));
`else
    logic unused_scl;
    assign unused_scl = scl_s2;
    assign freeze     = 1'b0;
`endif

    assign tick     = (state != IDLE) && !freeze;
    assign cell_end = tick && (q == 2'd3) && last_cnt;
    assign sample   = tick && (q == 2'd2) && last_cnt;
    assign accept   = (state == IDLE) && cmd_valid;

    always_comb begin
        state_n   = state;
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        case (state)
            IDLE:  if (cmd_valid) state_n = START;
            START: begin
                sda_oe = q[1];
                if (cell_end) state_n = ADDR;
            end
            ADDR: begin
                scl_oe = !q[1];
                sda_oe = !tx_sh[7];
                if (cell_end && bit_idx == 3'd7) state_n = AACK;
            end
            AACK: begin
                scl_oe = !q[1];
                if (cell_end) state_n = nack_q ? STOP : (rw_q ? RDATA : WDATA);
            end
            WDATA: begin
                scl_oe = !q[1];
                sda_oe = !tx_sh[7];
                if (cell_end && bit_idx == 3'd7) state_n = WACK;
            end
            WACK: begin
                scl_oe = !q[1];
                if (cell_end) state_n = STOP;
            end
            RDATA: begin
                scl_oe = !q[1];
                if (cell_end && bit_idx == 3'd7) state_n = MACK;
            end
            MACK: begin
                scl_oe = !q[1];
                if (cell_end) state_n = STOP;
            end
            STOP: begin
                scl_oe = !q[1];
                sda_oe = (q != 2'd3);
                if (cell_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= 2'd0;
            bit_idx   <= 3'd0;
            tx_sh     <= 8'h00;
            rx_sh     <= 8'h00;
            wdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            nack_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
        end else begin
            state     <= state_n;
            rsp_valid <= 1'b0;

            if (state == IDLE) begin
                cnt <= '0;
                q   <= 2'd0;
            end else if (tick) begin
                if (last_cnt) begin
                    cnt <= '0;
                    q   <= q + 2'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            if (accept) begin
                tx_sh   <= {cmd_addr, cmd_rw};
                rw_q    <= cmd_rw;
                wdata_q <= cmd_wdata;
                rx_sh   <= 8'h00;
                nack_q  <= 1'b0;
                bit_idx <= 3'd0;
            end

            if (sample) begin
                if ((state == AACK || state == WACK) && sda_s2) nack_q <= 1'b1;
                if (state == RDATA) rx_sh <= {rx_sh[6:0], sda_s2};
            end

            if (cell_end) begin
                case (state)
                    ADDR, WDATA: begin
                        bit_idx <= bit_idx + 3'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                    RDATA: bit_idx <= bit_idx + 3'd1;
                    AACK:  tx_sh   <= wdata_q;
                    STOP: begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rx_sh;
                        rsp_nack  <= nack_q;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with CLK_DIV=4 and an ACKing slave at 7'h42.
// Build with +define+I2C_MASTER_CLK_STRETCH_EN to exercise clock stretching.
module tb_i2c_master_byte;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
    logic [7:0] rsp_rdata;
    logic       scl, sda;
    logic       sl_sda_low = 1'b0;
    logic       sl_scl_low = 1'b0;

    assign scl = !(scl_oe | sl_scl_low);
    assign sda = !(sda_oe | sl_sda_low);

    i2c_master_byte #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl), .sda_in(sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: watches the bus on the falling clk edge and counts SCL rises since START.
    int         k = 0;
    int         starts = 0;
    logic       pscl = 1'b1, psda = 1'b1;
    logic [7:0] b0 = 8'h00, b1 = 8'h00, rbyte = 8'h00;
    logic       ack9 = 1'b1, ack18 = 1'b0, stop_seen = 1'b0, nack_data = 1'b0, clr_stop = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            k <= 0; sl_sda_low <= 1'b0; pscl <= 1'b1; psda <= 1'b1;
        end else begin
            if (clr_stop) stop_seen <= 1'b0;
            if (pscl && scl && psda && !sda) begin
                k <= 0; starts <= starts + 1; b0 <= 8'h00; b1 <= 8'h00;
            end else if (pscl && scl && !psda && sda) begin
                stop_seen <= 1'b1;
            end
            if (!pscl && scl) begin
                k <= k + 1;
                if (k + 1 <= 8) b0 <= {b0[6:0], sda};
                if (k + 1 == 9) ack9 <= sda;
                if (k + 1 >= 10 && k + 1 <= 17) b1 <= {b1[6:0], sda};
                if (k + 1 == 18) ack18 <= sda;
            end
            if (pscl && !scl) begin
                sl_sda_low <= 1'b0;
                if (k + 1 == 9 && b0[7:1] == 7'h42) sl_sda_low <= 1'b1;
                if (k >= 9 && k <= 16 && b0[7:1] == 7'h42 && b0[0])
                    sl_sda_low <= !rbyte[16 - k];
                if (k + 1 == 18 && b0[7:1] == 7'h42 && !b0[0] && !nack_data)
                    sl_sda_low <= 1'b1;
            end
            pscl <= scl;
            psda <= sda;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int t0 = 0;
    int lat;
    int seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] d);
        @(negedge clk);
        cmd_addr = a; cmd_rw = rw; cmd_wdata = d; cmd_valid = 1'b1; clr_stop = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        cmd_valid = 1'b0; clr_stop = 1'b0;
        cmd_addr = ~a; cmd_rw = ~rw; cmd_wdata = ~d;
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_rsp(output int l);
        l = -1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                l = cyc - t0;
                break;
            end
        end
    endtask

    task automatic wait_to(input int c);
        for (int i = 0; i < 1000 && (cyc - t0) < c; i++) @(negedge clk);
    endtask

    task automatic check_done(input string tag, input int exp_lat, input logic [7:0] exp_rd,
                              input logic exp_nack);
        wait_rsp(lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_nack"}, rsp_nack, exp_nack);
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_one_cycle"}, rsp_valid, 1'b0);
        chk({tag, "_stop"}, stop_seen, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_nack", rsp_nack, 1'b0);
        chk("rst_scl_oe", scl_oe, 1'b0);
        chk("rst_sda_oe", sda_oe, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: write 5A to 42; inputs are scrambled right after accept
        send(7'h42, 1'b0, 8'h5A);
        check_done("wr", 320, 8'h00, 1'b0);
        chk("wr_addr_byte", b0, 8'h84);
        chk("wr_data_byte", b1, 8'h5A);
        chk("wr_addr_ack", ack9, 1'b0);

        // 2: read from 42, slave returns C3
        rbyte = 8'hC3;
        send(7'h42, 1'b1, 8'h00);
        check_done("rd", 320, 8'hC3, 1'b0);
        chk("rd_addr_byte", b0, 8'h85);
        chk("rd_master_nack", ack18, 1'b1);

        // 3: absent address
        send(7'h10, 1'b0, 8'h77);
        check_done("absent", 176, 8'h00, 1'b1);
        chk("absent_addr_byte", b0, 8'h20);

        // 4: slave NACKs the data byte
        nack_data = 1'b1;
        send(7'h42, 1'b0, 8'hFF);
        check_done("dnack", 320, 8'h00, 1'b1);
        chk("dnack_data_byte", b1, 8'hFF);
        nack_data = 1'b0;

        // 5: reset during RDATA bit 3 (cell 13, Q1)
        rbyte = 8'h96;
        send(7'h42, 1'b1, 8'h00);
        wait_to(13 * 4 * DIV + DIV + 2);
        chk("pre_rst_scl_low", scl_oe, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_scl_oe", scl_oe, 1'b0);
        chk("midrst_sda_oe", sda_oe, 1'b0);
        chk("midrst_ready", cmd_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        send(7'h42, 1'b0, 8'hA5);
        check_done("post_rst", 320, 8'h00, 1'b0);
        chk("post_rst_data_byte", b1, 8'hA5);

        // 6: cmd_valid while busy is ignored; with stretching, slave holds SCL in AACK
        send(7'h42, 1'b0, 8'h3C);
        wait_to(50);
        cmd_addr = 7'h11; cmd_valid = 1'b1;
        #1;
        chk("busy_not_ready", cmd_ready, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
`ifdef I2C_MASTER_CLK_STRETCH_EN
        wait_to(9 * 4 * DIV + 6);
        sl_scl_low = 1'b1;
        wait_to(9 * 4 * DIV + 2 * DIV + 10);
        sl_scl_low = 1'b0;
        check_done("stretch", 330, 8'h00, 1'b0);
`else
        check_done("stretch", 320, 8'h00, 1'b0);
`endif
        chk("stretch_data_byte", b1, 8'h3C);
        seen = starts;
        repeat (4 * 4 * DIV) @(negedge clk);
        chk("ignored_no_second_start", starts, seen);
        chk("ignored_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
